// File: rtl/divider_seq_restoring.sv
`default_nettype none
// ============================================================================
// Module      : divider_seq_restoring
// Description : Multi-cycle unsigned restoring divider with valid/ready
//               handshakes. It produces one quotient bit per clock, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_seq_restoring #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_last_step = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] qsh_q, qsh_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;
    logic [WIDTH-1:0] w_prem_step;
    logic [WIDTH-1:0] w_qsh_step;

    // One restoring step; the partial remainder always stays below the
    // divisor, so it fits back into WIDTH bits whichever branch is taken.
    always_comb begin
        w_shift     = {prem_q, qsh_q[WIDTH-1]};
        w_trial     = w_shift - {1'b0, dvs_q};
        w_borrow    = w_trial[WIDTH];
        w_prem_step = w_borrow ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_qsh_step  = {qsh_q[WIDTH-2:0], ~w_borrow};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prem_d      = prem_q;
        qsh_d       = qsh_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    if (divisor == '0) begin
                        state_d     = S_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = '0;
                        prem_d  = '0;
                        qsh_d   = dividend;
                        dvs_d   = divisor;
                    end
                end
            end
            S_BUSY: begin
                cnt_d  = cnt_q + 1'b1;
                prem_d = w_prem_step;
                qsh_d  = w_qsh_step;
                if (cnt_q == c_last_step) begin
                    state_d     = S_DONE;
                    quotient_d  = w_qsh_step;
                    remainder_d = w_prem_step;
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            qsh_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            qsh_q       <= qsh_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_seq_restoring.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_seq_restoring
// Description : Scoreboard bench for divider_seq_restoring (WIDTH = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_seq_restoring;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    divider_seq_restoring #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Result-side scoreboard: every handshake pops and compares one entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result: got q=%h r=%h z=%b, required no result", quotient, remainder, div_by_zero);
            end else begin
                e = sb.pop_front();
                if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                    bad++;
                    $display("FAIL scoreboard: got q=%h r=%h z=%b, required q=%h r=%h z=%b",
                             quotient, remainder, div_by_zero, e.q, e.r, e.z);
                end
            end
        end
    end

    // Drives one operand pair; returns #1 after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h z=%b, required 1 0 0000 0000 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_basic;
        int lat;
        out_ready = 1'b1;
        send(16'd1000, 16'd7);
        wait_valid(lat);
        total++;
        if (lat !== 16) begin
            bad++;
            $display("FAIL basic_latency: got %0d, required 16", lat);
        end
        total++;
        if ({quotient, remainder, div_by_zero, in_ready} !== {16'd142, 16'd6, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL basic_result: got q=%0d r=%0d z=%b rdy=%b, required 142 6 0 0",
                     quotient, remainder, div_by_zero, in_ready);
        end
        @(posedge clk); #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL basic_release: got vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_boundaries;
        logic [W-1:0] a_tab [5] = '{16'hFFFF, 16'd5, 16'hFFFF, 16'd0, 16'd77};
        logic [W-1:0] b_tab [5] = '{16'd1, 16'd9, 16'hFFFF, 16'd3, 16'd77};
        logic [W-1:0] q_tab [5] = '{16'hFFFF, 16'd0, 16'd1, 16'd0, 16'd1};
        logic [W-1:0] r_tab [5] = '{16'd0, 16'd5, 16'd0, 16'd0, 16'd0};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(a_tab[i], b_tab[i]);
            wait_valid(lat);
            total++;
            if ({quotient, remainder} !== {q_tab[i], r_tab[i]}) begin
                bad++;
                $display("FAIL boundary_%0d: got q=%h r=%h, required q=%h r=%h",
                         i, quotient, remainder, q_tab[i], r_tab[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_zero;
        int lat;
        out_ready = 1'b1;
        send(16'h1234, 16'h0000);
        wait_valid(lat);
        // the result is already visible in the cycle right after the accept edge
        total++;
        if (lat !== 0) begin
            bad++;
            $display("FAIL dbz_latency: got %0d extra edges, required 0", lat);
        end
        total++;
        if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 16'h1234, 1'b1}) begin
            bad++;
            $display("FAIL dbz_result: got q=%h r=%h z=%b, required FFFF 1234 1",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int lat;
        int errs = 0;
        out_ready = 1'b0;
        send(16'd1000, 16'd7);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 16'd50;
            divisor  = 16'd5;
            @(posedge clk); #1;
            if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'd142, 16'd6, 1'b0})
                errs++;
        end
        in_valid = 1'b0;
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL backpressure_hold: got %0d unstable cycles, required 0", errs);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        int seen = 0;
        out_ready = 1'b1;
        send(16'd1000, 16'd7);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_back());
        total++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
            bad++;
            $display("FAIL abort_state: got rdy=%b vld=%b q=%h r=%h z=%b, required 1 0 0000 0000 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL abort_no_result: got %0d valid cycles, required 0", seen);
        end
        send(16'd100, 16'd10);
        wait_valid(lat);
        total++;
        if ({quotient, remainder, div_by_zero} !== {16'd10, 16'd0, 1'b0}) begin
            bad++;
            $display("FAIL abort_next: got q=%0d r=%0d z=%b, required 10 0 0", quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         hs;
        int           n;
        for (int k = 0; k < 2000; k++) begin
            a = W'($urandom);
            case ($urandom_range(0, 9))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 15));
                3:       b = a;
                default: b = W'($urandom);
            endcase
            out_ready = 1'($urandom_range(0, 1));
            send(a, b);
            hs = 1'b0;
            n  = 0;
            while (!hs && n < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                hs = out_valid && out_ready;
                @(posedge clk); #1;
                n++;
            end
            if (!hs) begin
                total++;
                bad++;
                $display("FAIL random_timeout: op %0d got no handshake, required one", k);
            end
        end
        out_ready = 1'b1;
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
